// File: rtl/regfile_mp_if.sv
// regfile_mp_if: read/write bus of the multi-port register file.
// Flat per-port vectors: read port i uses rs[i*AW +: AW] / rdata[i*XLEN +: XLEN],
// write port j uses rd[j*AW +: AW] / wdata[j*XLEN +: XLEN] / we[j].
interface regfile_mp_if #(
    parameter int XLEN      = 32,
    parameter int NREGS     = 32,
    parameter int NUM_READ  = 2,
    parameter int NUM_WRITE = 1
);
    localparam int AW = $clog2(NREGS);

    logic [NUM_READ*AW-1:0]    rs;
    logic [NUM_READ*XLEN-1:0]  rdata;
    logic [NUM_WRITE*AW-1:0]   rd;
    logic [NUM_WRITE-1:0]      we;
    logic [NUM_WRITE*XLEN-1:0] wdata;
    logic                      busy;

    // decode/writeback side
    modport master (output rs, rd, we, wdata, input rdata, busy);
    // register file side
    modport slave  (input rs, rd, we, wdata, output rdata, busy);
endinterface

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port integer register file.
// After reset the array is cleared one register per clock (busy high, reads 0,
// writes ignored), then normal operation starts. Reads are combinational.
// Optional macro REGFILE_BYPASS_EN: forward same-cycle write data to matching
// read ports (highest write port wins), removing the writeback-to-decode hazard.
module regfile_mp #(
    parameter int XLEN      = 32,
    parameter int NREGS     = 32,
    parameter int NUM_READ  = 2,
    parameter int NUM_WRITE = 1,
    parameter int ZERO_REG  = 1
) (
    input  logic          clk,
    input  logic          rst,
    regfile_mp_if.slave   bus
);
    localparam int AW = $clog2(NREGS);
    localparam bit ZR = (ZERO_REG != 0);

    typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   clr_idx_q, clr_idx_d;

    // storage has no reset; the CLEAR sequence zeroes it
    logic [XLEN-1:0] regs [NREGS];

    logic [NUM_WRITE-1:0][AW-1:0]   wr_addr;
    logic [NUM_WRITE-1:0][XLEN-1:0] wr_data;
    logic [NUM_WRITE-1:0]           wen;

    // unpack write ports; writes to reg 0 are dropped when it is hardwired
    for (genvar j = 0; j < NUM_WRITE; j++) begin : g_wr
        assign wr_addr[j] = bus.rd[j*AW +: AW];
        assign wr_data[j] = bus.wdata[j*XLEN +: XLEN];
        assign wen[j]     = bus.we[j] && !(ZR && (wr_addr[j] == '0));
    end

    // state and clear counter; rst restarts the clear from index 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= CLEAR;
            clr_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    // next state: walk every index once, leave CLEAR on the last one
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        if (state_q == CLEAR) begin
            clr_idx_d = clr_idx_q + 1'b1;
            if (clr_idx_q == AW'(NREGS - 1))
                state_d = RUN;
        end
    end

    assign bus.busy = (state_q == CLEAR);

    // array update: clear one entry per clock, else commit writes in port
    // order so the highest port index wins an address collision
    always_ff @(posedge clk) begin
        if (state_q == CLEAR) begin
            regs[clr_idx_q] <= '0;
        end else begin
            for (int j = 0; j < NUM_WRITE; j++)
                if (wen[j])
                    regs[wr_addr[j]] <= wr_data[j];
        end
    end

    // read ports
    for (genvar i = 0; i < NUM_READ; i++) begin : g_rd
        logic [AW-1:0]   ra;
        logic [XLEN-1:0] val;

        assign ra = bus.rs[i*AW +: AW];

        // array read, forced to 0 during clear and for hardwired reg 0
        always_comb begin
            val = '0;
            if (state_q == RUN && !(ZR && (ra == '0))) begin
                val = regs[ra];
`ifdef REGFILE_BYPASS_EN
                // later ports override earlier ones, matching write priority
                for (int j = 0; j < NUM_WRITE; j++)
                    if (wen[j] && (wr_addr[j] == ra))
                        val = wr_data[j];
`endif
            end
        end

        assign bus.rdata[i*XLEN +: XLEN] = val;
    end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: table-driven vectors plus hand sequences for clear/reset
// corners. Expected values are queued when stimulus is driven and popped when
// the DUT outputs are sampled. Two DUTs: ZERO_REG=1 (a) and ZERO_REG=0 (b).
module tb_regfile_mp;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    regfile_mp_if #(.XLEN(32), .NREGS(32), .NUM_READ(2), .NUM_WRITE(2)) ba ();
    regfile_mp_if #(.XLEN(32), .NREGS(32), .NUM_READ(2), .NUM_WRITE(2)) bb ();

    regfile_mp #(.XLEN(32), .NREGS(32), .NUM_READ(2), .NUM_WRITE(2), .ZERO_REG(1))
        dut_a (.clk(clk), .rst(rst), .bus(ba));
    regfile_mp #(.XLEN(32), .NREGS(32), .NUM_READ(2), .NUM_WRITE(2), .ZERO_REG(0))
        dut_b (.clk(clk), .rst(rst), .bus(bb));

    typedef struct {
        string       name;
        logic [31:0] exp;
    } sb_t;
    sb_t sbq [$];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]  we;
        logic [4:0]  rd0, rd1;
        logic [31:0] wd0, wd1;
        logic [4:0]  rs0, rs1;
        logic [31:0] e0, e1;
    } vec_t;
    vec_t tbl [12];

    task automatic push(input string name, input logic [31:0] exp);
        sb_t e;
        e.name = name;
        e.exp  = exp;
        sbq.push_back(e);
    endtask

    task automatic check(input logic [31:0] act);
        sb_t e;
        checks++;
        if (sbq.size() == 0) begin
            errors++;
            $display("FAIL sb_underflow: got %h with nothing expected", act);
        end else begin
            e = sbq.pop_front();
            if (act !== e.exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
            end
        end
    endtask

    task automatic drive_a(input logic [1:0] we, input logic [4:0] rd0, input logic [4:0] rd1,
                           input logic [31:0] wd0, input logic [31:0] wd1,
                           input logic [4:0] rs0, input logic [4:0] rs1);
        ba.we    = we;
        ba.rd    = {rd1, rd0};
        ba.wdata = {wd1, wd0};
        ba.rs    = {rs1, rs0};
    endtask

    task automatic drive_b(input logic [1:0] we, input logic [4:0] rd0,
                           input logic [31:0] wd0, input logic [4:0] rs0);
        bb.we    = we;
        bb.rd    = {5'd0, rd0};
        bb.wdata = {32'd0, wd0};
        bb.rs    = {5'd0, rs0};
    endtask

    // count edges until busy drops; a run-away clear is reported, not hung on
    task automatic wait_clear(input string name);
        int n;
        n = 0;
        while (ba.busy === 1'b1 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        ba.we = 2'b00;
        bb.we = 2'b00;
        push(name, 32'd32);
        check(32'(n));
    endtask

    // read-pair check on DUT a at the current drive point
    task automatic read_a(input string name, input logic [4:0] rs0, input logic [4:0] rs1,
                          input logic [31:0] e0, input logic [31:0] e1);
        @(negedge clk);
        drive_a(2'b00, 5'd0, 5'd0, 32'd0, 32'd0, rs0, rs1);
        push({name, "_r0"}, e0);
        push({name, "_r1"}, e1);
        #2;
        check(ba.rdata[31:0]);
        check(ba.rdata[63:32]);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0]  = '{2'b11, 5'd4,  5'd7,  32'h11,       32'h22,       5'd1,  5'd2,  32'h0,    32'h0};
        tbl[1]  = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        5'd4,  5'd7,  32'h11,   32'h22};
        tbl[2]  = '{2'b11, 5'd9,  5'd9,  32'hAAAA,     32'hBBBB,     5'd4,  5'd7,  32'h11,   32'h22};
        tbl[3]  = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        5'd9,  5'd9,  32'hBBBB, 32'hBBBB};
        tbl[4]  = '{2'b01, 5'd0,  5'd0,  32'hFFFFFFFF, 32'h0,        5'd9,  5'd4,  32'hBBBB, 32'h11};
        tbl[5]  = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        5'd0,  5'd31, 32'h0,    32'h0};
        tbl[6]  = '{2'b10, 5'd5,  5'd31, 32'h5555,     32'hCAFE,     5'd5,  5'd0,  32'h0,    32'h0};
        tbl[7]  = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        5'd31, 5'd5,  32'hCAFE, 32'h0};
        tbl[8]  = '{2'b11, 5'd31, 5'd30, 32'h1,        32'h2,        5'd4,  5'd9,  32'h11,   32'hBBBB};
        tbl[9]  = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        5'd31, 5'd30, 32'h1,    32'h2};
        tbl[10] = '{2'b10, 5'd0,  5'd0,  32'h0,        32'hFFFFFFFF, 5'd30, 5'd1,  32'h2,    32'h0};
        tbl[11] = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        5'd0,  5'd0,  32'h0,    32'h0};

        // reset state
        drive_a(2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 5'd3, 5'd5);
        drive_b(2'b00, 5'd0, 32'd0, 5'd0);
        rst = 1'b1;
        @(negedge clk);
        push("rst_busy_a", 32'd1);
        push("rst_busy_b", 32'd1);
        push("rst_rdata_a", 64'd0);
        push("rst_rdata_b0", 32'd0);
        #2;
        check(32'(ba.busy));
        check(32'(bb.busy));
        check(ba.rdata[31:0] | ba.rdata[63:32]);
        check(bb.rdata[31:0]);
        @(negedge clk);
        rst = 1'b0;
        wait_clear("init_clear_len");

        // table vectors on DUT a
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            drive_a(tbl[k].we, tbl[k].rd0, tbl[k].rd1, tbl[k].wd0, tbl[k].wd1,
                    tbl[k].rs0, tbl[k].rs1);
            push($sformatf("vec%0d_r0", k), tbl[k].e0);
            push($sformatf("vec%0d_r1", k), tbl[k].e1);
            #2;
            check(ba.rdata[31:0]);
            check(ba.rdata[63:32]);
        end

        // same-cycle write/read: forwarded only with bypass
        @(negedge clk);
        drive_a(2'b01, 5'd12, 5'd0, 32'h1234, 32'd0, 5'd12, 5'd12);
        push("byp_r0", BYP ? 32'h1234 : 32'h0);
        push("byp_r1", BYP ? 32'h1234 : 32'h0);
        #2;
        check(ba.rdata[31:0]);
        check(ba.rdata[63:32]);
        read_a("byp_next", 5'd12, 5'd12, 32'h1234, 32'h1234);

        // colliding writes with a same-cycle read: highest port forwarded
        @(negedge clk);
        drive_a(2'b11, 5'd13, 5'd13, 32'hAAAA, 32'hBBBB, 5'd13, 5'd12);
        push("byp_coll_r0", BYP ? 32'hBBBB : 32'h0);
        push("byp_coll_r1", 32'h1234);
        #2;
        check(ba.rdata[31:0]);
        check(ba.rdata[63:32]);
        read_a("coll_next", 5'd13, 5'd12, 32'hBBBB, 32'h1234);

        // ZERO_REG=0: reg 0 is an ordinary register
        @(negedge clk);
        drive_b(2'b01, 5'd0, 32'hFFFFFFFF, 5'd0);
        push("zr0_same", BYP ? 32'hFFFFFFFF : 32'h0);
        #2;
        check(bb.rdata[31:0]);
        @(negedge clk);
        drive_b(2'b00, 5'd0, 32'd0, 5'd0);
        push("zr0_next", 32'hFFFFFFFF);
        #2;
        check(bb.rdata[31:0]);

        // reset clear: preload, pulse rst, write during busy must not commit
        @(negedge clk);
        drive_a(2'b01, 5'd5, 5'd0, 32'hDEADBEEF, 32'd0, 5'd0, 5'd0);
        read_a("preload", 5'd5, 5'd13, 32'hDEADBEEF, 32'hBBBB);
        rst = 1'b1;
        #1;
        push("rst_async_busy", 32'd1);
        push("rst_async_rdata", 32'd0);
        check(32'(ba.busy));
        check(ba.rdata[31:0]);
        @(negedge clk);
        rst = 1'b0;
        drive_a(2'b01, 5'd3, 5'd0, 32'h12345678, 32'd0, 5'd5, 5'd3);
        push("clr_rd_r0", 32'd0);
        push("clr_rd_r1", 32'd0);
        #2;
        check(ba.rdata[31:0]);
        check(ba.rdata[63:32]);
        wait_clear("clear_len");
        read_a("after_clear", 5'd5, 5'd3, 32'd0, 32'd0);

        // reset mid-clear at clr_idx=10 restarts the full sequence
        @(negedge clk);
        drive_a(2'b11, 5'd20, 5'd21, 32'h7777, 32'h3333, 5'd0, 5'd0);
        read_a("mid_pre", 5'd20, 5'd21, 32'h7777, 32'h3333);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        push("mid_busy", 32'd1);
        check(32'(ba.busy));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wait_clear("midclr_len");
        for (int r = 0; r < 32; r++)
            read_a($sformatf("midclr_reg%0d", r), 5'(r), 5'(31 - r), 32'd0, 32'd0);

        if (sbq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL sb_leftover: got %0d entries expected 0", sbq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port integer register file; next generation of the pipeline register file.
- Configurable data width, register count and number of read/write ports.
- Sequential hardware clear after reset, with a busy indication.
- Sits in decode (reads) and writeback (writes); the hazard unit stalls issue while busy is high.

Parameters:
- XLEN, 32: register data width in bits.
- NREGS, 32: number of architectural registers; power of two, at least 2. Localparam AW = $clog2(NREGS).
- NUM_READ, 2: number of read ports.
- NUM_WRITE, 1: number of write ports.
- ZERO_REG, 1: when 1, register 0 is hardwired to zero.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- rs  in  NUM_READ*AW  read addresses; port i uses bits [i*AW +: AW].
- rdata  out  NUM_READ*XLEN  read data; port i uses bits [i*XLEN +: XLEN].
- rd  in  NUM_WRITE*AW  write addresses; port j uses bits [j*AW +: AW].
- we  in  NUM_WRITE  per-port write enable.
- wdata  in  NUM_WRITE*XLEN  write data; port j uses bits [j*XLEN +: XLEN].
- busy  out  1  high while the clear sequence runs; writes are ignored and reads return 0.

Behaviour:
- Reset: clock is clk; reset rst is asynchronous and active-high.
- State machine: two states, CLEAR and RUN, plus a clear counter clr_idx of width AW.
- rst asserted (asynchronous): state=CLEAR, clr_idx=0, busy=1 immediately.
- Storage array is not asynchronously reset; it is cleared sequentially.
- CLEAR, each clock edge with rst low: registers[clr_idx] <= 0, clr_idx <= clr_idx+1.
  - On the edge where clr_idx==NREGS-1: state <= RUN, busy <= 0.
  - Clear therefore takes exactly NREGS edges after rst deasserts; busy falls on edge NREGS.
- rst re-asserted mid-clear: sequence restarts at clr_idx=0.
- CLEAR: all we ignored; every rdata reads 0.
- RUN: busy=0; clr_idx holds.
- Writes in RUN: for each port j with we[j]=1, registers[rd_j] <= wdata_j on the edge.
  - rd_j==0 with ZERO_REG=1: write dropped.
  - Several ports writing the same address in one cycle: highest port index wins; the others are dropped.
  - Writes to distinct addresses all commit in the same cycle.
- Reads (combinational, zero latency): rdata_i = registers[rs_i].
  - rs_i==0 with ZERO_REG=1: rdata_i = 0, regardless of array contents.
  - Without bypass, a same-cycle write is visible on the cycle after the edge.
- Address width: exactly AW bits; no out-of-range addresses are possible.
- Reset values: busy=1, rdata=0 on all ports (forced by CLEAR), state=CLEAR, clr_idx=0.

Optional Feature:
- Macro REGFILE_BYPASS_EN.
- Defined: in RUN, if any port j has we[j]=1 and rd_j==rs_i (excluding reg 0 when ZERO_REG=1), rdata_i = wdata_j combinationally.
  - With several matching ports, the highest j is forwarded.
  - Write-to-read latency becomes 0 cycles; this removes the writeback-to-decode hazard.
  - No bypass during CLEAR; rdata stays 0.
- Undefined: no forwarding; reads return array contents only, so new data is visible one cycle after the write.

Test Plan:
- Reset clear: preload reg 5=32'hDEADBEEF, pulse rst, release -> busy=1 for exactly 32 edges; afterwards rdata for rs=5 is 0; a we=1 to rd=3 issued during busy does not commit (reg 3 reads 0 after clear).
- Basic write/read: NUM_WRITE=2, port0 writes rd=4 with 32'h11, port1 writes rd=7 with 32'h22 in the same cycle -> next cycle rs0=4 reads 32'h11, rs1=7 reads 32'h22.
- Collision: both write ports target rd=9 (port0 32'hAAAA, port1 32'hBBBB) -> reg 9 reads 32'hBBBB.
- Zero register: we=1, rd=0, wdata=32'hFFFFFFFF -> rs=0 reads 0; with ZERO_REG=0, it reads 32'hFFFFFFFF.
- Bypass: write rd=12 with 32'h1234 while rs0=12 in the same cycle -> with REGFILE_BYPASS_EN, rdata0=32'h1234 that cycle; without it, rdata0 shows the old value and 32'h1234 the next cycle.
- Reset mid-clear: assert rst at clr_idx=10 -> after release busy stays high a full NREGS cycles, and all registers read 0.
